// File: rtl/psram_resp_pkg.sv
// rtl/psram_resp_pkg.sv - shared psram responder types and constants
package psram_resp_pkg;

    localparam int ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INST  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_LATN  = 3'd3,
        ST_WDATA = 3'd4,
        ST_RDATA = 3'd5,
        ST_SKIP  = 3'd6
    } state_t;

endpackage

// File: rtl/psram_resp_if.sv
// rtl/psram_resp_if.sv - byte memory access bus between responder and backing store
interface psram_resp_if #(parameter int MEM_AW = 16);

    logic              req;
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;

    modport master (output req, we, addr, wdata, input rdata);
    modport slave  (input req, we, addr, wdata, output rdata);

endinterface

// File: rtl/dffer.sv
// rtl/dffer.sv - resettable flop cell with load enable
module dffer #(
    parameter int           W   = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RST;
        else if (en) q <= d;
    end

endmodule

// File: rtl/dffr.sv
// rtl/dffr.sv - resettable flop cell
module dffr #(
    parameter int           W   = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST;
        else        q <= d;
    end

endmodule

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rise/fall detector on an already-synchronous signal
module edge_det #(parameter logic RST = 1'b0) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev;

    dffr #(.W(1), .RST(RST)) u_prev (.clk(clk), .rst_n(rst_n), .d(d), .q(prev));

    assign rise = d & ~prev;
    assign fall = ~d & prev;

endmodule

// File: rtl/psram_resp_sync.sv
// rtl/psram_resp_sync.sv - single register stage for the psram pins plus SCK/CE edge pulses
module psram_resp_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ce,
    input  logic [7:0] io,
    input  logic       dqs,
    output logic [7:0] io_r,
    output logic       dqs_r,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_rise,
    output logic       ce_fall
);

    logic sck_r;
    logic ce_r;

    dffr #(.W(1), .RST(1'b0)) u_sck (.clk(clk), .rst_n(rst_n), .d(sck), .q(sck_r));
    dffr #(.W(1), .RST(1'b1)) u_ce  (.clk(clk), .rst_n(rst_n), .d(ce),  .q(ce_r));
    dffr #(.W(8), .RST(8'h00)) u_io (.clk(clk), .rst_n(rst_n), .d(io),  .q(io_r));
    dffr #(.W(1), .RST(1'b0)) u_dqs (.clk(clk), .rst_n(rst_n), .d(dqs), .q(dqs_r));

    // ce edge history resets high so reset release with ce idle yields no edge
    edge_det #(.RST(1'b0)) u_sck_edge (.clk(clk), .rst_n(rst_n), .d(sck_r), .rise(sck_rise), .fall(sck_fall));
    edge_det #(.RST(1'b1)) u_ce_edge  (.clk(clk), .rst_n(rst_n), .d(ce_r),  .rise(ce_rise),  .fall(ce_fall));

endmodule

// File: rtl/psram_resp.sv
// rtl/psram_resp.sv - DDR psram device-side responder bridging to a byte memory bus
module psram_resp
    import psram_resp_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         psram_sck_i,
    input  logic         psram_ce_i,
    input  logic [7:0]   psram_io_in_i,
    output logic [7:0]   psram_io_out_o,
    output logic         psram_io_en_o,
    input  logic         psram_dqs_in_i,
    output logic         psram_dqs_out_o,
    output logic         psram_dqs_en_o,
    input  logic [7:0]   cfg_wcmd_i,
    input  logic [7:0]   cfg_rcmd_i,
    input  logic [7:0]   cfg_wlc_i,
    input  logic [7:0]   cfg_rlc_i,
    psram_resp_if.master mem,
    output logic         xfer_done_o,
    output logic         cmd_err_o
);

    logic [7:0]        io_r;
    logic              dqs_r, sck_rise, sck_fall, ce_rise, ce_fall, sck_edge;
    state_t            state, state_nxt, data_st;
    logic [2:0]        state_q;
    logic [7:0]        op, lat, lat_cnt, pbuf, io_out;
    logic              is_wr, rd_pend, dqs_out;
    logic [1:0]        cnt;
    logic [MEM_AW-1:0] addr, addr_shift, base, addr_d;
    logic              addr_last, lat_done, rd_entry, wr_hit, rd_hit, addr_en, out_en;

    psram_resp_sync u_sync (
        .clk(clk_i), .rst_n(rst_n_i), .sck(psram_sck_i), .ce(psram_ce_i),
        .io(psram_io_in_i), .dqs(psram_dqs_in_i), .io_r(io_r), .dqs_r(dqs_r),
        .sck_rise(sck_rise), .sck_fall(sck_fall), .ce_rise(ce_rise), .ce_fall(ce_fall)
    );

    // an edge coinciding with ce rise is dropped; the transaction is over
    assign sck_edge   = (sck_rise | sck_fall) & ~ce_rise;
    assign lat        = is_wr ? cfg_wlc_i : cfg_rlc_i;
    assign data_st    = is_wr ? ST_WDATA : ST_RDATA;
    assign addr_shift = {addr[MEM_AW-9:0], io_r};
    assign addr_last  = (state == ST_ADDR) && sck_edge && (cnt == 2'(ADDR_BYTES - 1));
    assign lat_done   = (state == ST_LATN) && sck_rise && !ce_rise && (lat_cnt == lat - 8'd1);
    assign rd_entry   = !is_wr && ((addr_last && lat == 8'd0) || lat_done);
    assign wr_hit     = (state == ST_WDATA) && sck_edge && dqs_r;
    assign rd_hit     = rd_entry || ((state == ST_RDATA) && sck_edge);
    assign base       = (state == ST_ADDR) ? addr_shift : addr;
    assign addr_en    = ((state == ST_ADDR || state == ST_WDATA) && sck_edge) || rd_hit;
    assign addr_d     = (state == ST_ADDR && !rd_entry) ? addr_shift : base + MEM_AW'(1);
    assign out_en     = ((state == ST_RDATA) && sck_edge) || (state == ST_IDLE);

    dffr #(.W(3), .RST(ST_IDLE)) u_state (.clk(clk_i), .rst_n(rst_n_i), .d(state_nxt), .q(state_q));
    assign state = state_t'(state_q);

    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && ce_rise) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ce_fall) state_nxt = ST_INST;
                ST_INST: if (sck_fall)
                    state_nxt = (op == cfg_wcmd_i || op == cfg_rcmd_i) ? ST_ADDR : ST_SKIP;
                ST_ADDR: if (addr_last) state_nxt = (lat == 8'd0) ? data_st : ST_LATN;
                ST_LATN: if (lat_done) state_nxt = data_st;
                default: ;
            endcase
        end
    end

    dffer #(.W(8)) u_op (.clk(clk_i), .rst_n(rst_n_i), .en(state == ST_INST && sck_rise),
                         .d(io_r), .q(op));
    dffer #(.W(1)) u_is_wr (.clk(clk_i), .rst_n(rst_n_i), .en(state == ST_INST && sck_fall),
                            .d(op == cfg_wcmd_i), .q(is_wr));
    dffer #(.W(2)) u_cnt (.clk(clk_i), .rst_n(rst_n_i),
                          .en(state == ST_INST || (state == ST_ADDR && sck_edge)),
                          .d(state == ST_INST ? 2'd0 : cnt + 2'd1), .q(cnt));
    dffer #(.W(8)) u_lat_cnt (.clk(clk_i), .rst_n(rst_n_i),
                              .en(addr_last || (state == ST_LATN && sck_rise)),
                              .d(addr_last ? 8'd0 : lat_cnt + 8'd1), .q(lat_cnt));
    dffer #(.W(MEM_AW)) u_addr (.clk(clk_i), .rst_n(rst_n_i), .en(addr_en), .d(addr_d), .q(addr));

    // read data lands one clock after its request; drop it once the read is gone
    dffr  #(.W(1)) u_rd_pend (.clk(clk_i), .rst_n(rst_n_i), .d(rd_hit), .q(rd_pend));
    dffer #(.W(8)) u_pbuf (.clk(clk_i), .rst_n(rst_n_i), .en(rd_pend && state == ST_RDATA),
                           .d(mem.rdata), .q(pbuf));
    dffer #(.W(8)) u_io_out (.clk(clk_i), .rst_n(rst_n_i), .en(out_en),
                             .d(state == ST_IDLE ? 8'h00 : pbuf), .q(io_out));
    dffer #(.W(1)) u_dqs_out (.clk(clk_i), .rst_n(rst_n_i), .en(out_en),
                              .d(state == ST_IDLE ? 1'b0 : ~dqs_out), .q(dqs_out));

    always_comb begin
        xfer_done_o     = (state != ST_IDLE) && ce_rise;
        cmd_err_o       = (state == ST_SKIP) && ce_rise;
        psram_io_en_o   = (state == ST_RDATA);
        psram_dqs_en_o  = (state == ST_RDATA);
        psram_io_out_o  = io_out;
        psram_dqs_out_o = dqs_out;
        mem.req         = wr_hit || rd_hit;
        mem.we          = wr_hit;
        mem.addr        = (wr_hit || rd_hit) ? base : '0;
        mem.wdata       = wr_hit ? io_r : 8'h00;
    end

endmodule

// File: tb/tb_psram_resp.sv
// tb/tb_psram_resp.sv - directed self-checking bench for psram_resp
module tb_psram_resp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       ce = 1'b1;
    logic       dqs = 1'b0;
    logic [7:0] io = 8'h00;
    logic [7:0] wcmd = 8'hA0, rcmd = 8'h20, wlc = 8'd2, rlc = 8'd3;
    logic [7:0] io_out;
    logic       io_en, dqs_out, dqs_en, xfer_done, cmd_err;

    int checks = 0;
    int errors = 0;
    int req_n = 0, wr_n = 0, done_n = 0, err_n = 0, both_n = 0;
    int r0, w0, d0, e0, b0;
    logic [15:0] wr_addr [0:63];
    logic [7:0]  wr_data [0:63];

    psram_resp_if #(.MEM_AW(16)) mem ();

    psram_resp #(.MEM_AW(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .psram_sck_i(sck), .psram_ce_i(ce),
        .psram_io_in_i(io), .psram_io_out_o(io_out), .psram_io_en_o(io_en),
        .psram_dqs_in_i(dqs), .psram_dqs_out_o(dqs_out), .psram_dqs_en_o(dqs_en),
        .cfg_wcmd_i(wcmd), .cfg_rcmd_i(rcmd), .cfg_wlc_i(wlc), .cfg_rlc_i(rlc),
        .mem(mem), .xfer_done_o(xfer_done), .cmd_err_o(cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h0010: rom = 8'h55;
            16'h0011: rom = 8'h66;
            default:  rom = 8'hEE;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem.req) req_n <= req_n + 1;
        if (mem.req && mem.we) begin
            wr_addr[wr_n % 64] <= mem.addr;
            wr_data[wr_n % 64] <= mem.wdata;
            wr_n <= wr_n + 1;
        end
        if (mem.req && !mem.we) mem.rdata <= rom(mem.addr);
        if (xfer_done) done_n <= done_n + 1;
        if (cmd_err) err_n <= err_n + 1;
        if (xfer_done && cmd_err) both_n <= both_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic snap();
        r0 = req_n; w0 = wr_n; d0 = done_n; e0 = err_n; b0 = both_n;
    endtask

    task automatic sck_step(input logic [7:0] d, input logic s);
        @(negedge clk);
        io = d; dqs = s; sck = ~sck;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic begin_xfer(input logic [7:0] opc, input logic [31:0] a);
        @(negedge clk);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        sck_step(opc, 1'b0);
        sck_step(opc, 1'b0);
        for (int i = 3; i >= 0; i--) sck_step(a[8*i +: 8], 1'b0);
    endtask

    task automatic lat_edges(input int n);
        for (int i = 0; i < 2 * n - 1; i++) sck_step(8'h00, 1'b0);
    endtask

    task automatic end_xfer();
        @(negedge clk);
        ce = 1'b1;
        repeat (3) @(negedge clk);
        sck = 1'b0; dqs = 1'b0; io = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_io_out", {24'h0, io_out}, 32'h0);
        check("rst_en", {28'h0, io_en, dqs_en, dqs_out, 1'b0}, 32'h0);
        check("rst_pulses", {30'h0, xfer_done, cmd_err}, 32'h0);
        check("rst_mem", {mem.req, mem.we, 6'h0, mem.wdata, mem.addr}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // four-byte write, all strobes set
        snap();
        begin_xfer(8'hA0, 32'h0000_1234);
        lat_edges(2);
        sck_step(8'h11, 1'b1); sck_step(8'h22, 1'b1);
        sck_step(8'h33, 1'b1); sck_step(8'h44, 1'b1);
        end_xfer();
        check("wr4_count", wr_n - w0, 4);
        check("wr4_a0", {wr_addr[w0 % 64], wr_data[w0 % 64]}, 32'h0012_3411);
        check("wr4_a1", {wr_addr[(w0+1) % 64], wr_data[(w0+1) % 64]}, 32'h0012_3522);
        check("wr4_a2", {wr_addr[(w0+2) % 64], wr_data[(w0+2) % 64]}, 32'h0012_3633);
        check("wr4_a3", {wr_addr[(w0+3) % 64], wr_data[(w0+3) % 64]}, 32'h0012_3744);
        check("wr4_done", done_n - d0, 1);
        check("wr4_err", err_n - e0, 0);

        // strobe pattern 1,0,1,0
        snap();
        begin_xfer(8'hA0, 32'h0000_1234);
        lat_edges(2);
        sck_step(8'h11, 1'b1); sck_step(8'h22, 1'b0);
        sck_step(8'h33, 1'b1); sck_step(8'h44, 1'b0);
        end_xfer();
        check("dqs_count", wr_n - w0, 2);
        check("dqs_w0", {wr_addr[w0 % 64], wr_data[w0 % 64]}, 32'h0012_3411);
        check("dqs_w1", {wr_addr[(w0+1) % 64], wr_data[(w0+1) % 64]}, 32'h0012_3633);
        check("dqs_reqs", req_n - r0, 2);

        // read two bytes at 0x10 with latency 3
        snap();
        begin_xfer(8'h20, 32'h0000_0010);
        check("rd_en_pre", {30'h0, io_en, dqs_en}, 32'h0);
        lat_edges(3);
        check("rd_en_in", {30'h0, io_en, dqs_en}, 32'h3);
        check("rd_dqs_init", {31'h0, dqs_out}, 32'h0);
        sck_step(8'h00, 1'b0);
        check("rd_b0", {23'h0, dqs_out, io_out}, 32'h0000_0155);
        sck_step(8'h00, 1'b0);
        check("rd_b1", {23'h0, dqs_out, io_out}, 32'h0000_0066);
        end_xfer();
        check("rd_en_post", {30'h0, io_en, dqs_en}, 32'h0);
        check("rd_reqs", req_n - r0, 3);
        check("rd_writes", wr_n - w0, 0);
        check("rd_done", done_n - d0, 1);

        // unknown opcode
        snap();
        begin_xfer(8'h99, 32'h0000_1234);
        sck_step(8'h11, 1'b1); sck_step(8'h22, 1'b1);
        end_xfer();
        check("bad_reqs", req_n - r0, 0);
        check("bad_done", done_n - d0, 1);
        check("bad_err", err_n - e0, 1);
        check("bad_together", both_n - b0, 1);

        // zero latency, wrap at 0xFFFF, then ce rise racing an edge
        wlc = 8'd0;
        snap();
        begin_xfer(8'hA0, 32'h0000_FFFF);
        sck_step(8'hAA, 1'b1); sck_step(8'hBB, 1'b1);
        @(negedge clk);
        ce = 1'b1; sck = ~sck; io = 8'hCC; dqs = 1'b1;
        repeat (3) @(negedge clk);
        sck = 1'b0; dqs = 1'b0;
        repeat (3) @(negedge clk);
        wlc = 8'd2;
        check("wrap_count", wr_n - w0, 2);
        check("wrap_w0", {wr_addr[w0 % 64], wr_data[w0 % 64]}, 32'h00FF_FFAA);
        check("wrap_w1", {wr_addr[(w0+1) % 64], wr_data[(w0+1) % 64]}, 32'h0000_00BB);
        check("wrap_done", done_n - d0, 1);

        // abort after the second address byte
        snap();
        @(negedge clk);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        sck_step(8'hA0, 1'b0); sck_step(8'hA0, 1'b0);
        sck_step(8'h00, 1'b0); sck_step(8'h00, 1'b0);
        end_xfer();
        check("abort_reqs", req_n - r0, 0);
        check("abort_done", done_n - d0, 1);
        check("abort_outs", {io_en, dqs_en, dqs_out, mem.req, 4'h0, io_out}, 32'h0);

        // reset in the middle of a write
        snap();
        begin_xfer(8'hA0, 32'h0000_1234);
        lat_edges(2);
        sck_step(8'h11, 1'b1);
        check("rstmid_first", wr_n - w0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_outs", {io_en, dqs_en, mem.req, mem.we, xfer_done, 3'h0, mem.addr}, 32'h0);
        ce = 1'b1; sck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        snap();
        sck_step(8'h22, 1'b1); sck_step(8'h33, 1'b1);
        sck_step(8'h44, 1'b1); sck_step(8'h55, 1'b1);
        check("rstmid_reqs", req_n - r0, 0);
        check("rstmid_done", done_n - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
